// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the frame-buffer write port among up to four
// pixel generators, with bounded bursts and a one-entry output register.
module fb_write_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [16*NUM_REQ-1:0]  req_addr,
  input  logic [4*NUM_REQ-1:0]   req_wben,
  input  logic [NUM_REQ-1:0]     req_rts,
  output logic [NUM_REQ-1:0]     req_rtr,
  output logic [31:0]            mem_data,
  output logic [15:0]            mem_addr,
  output logic [3:0]             mem_wben,
  output logic                   mem_rts,
  input  logic                   mem_rtr,
  output logic [1:0]             grant_id,
  output logic                   busy
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;

  logic        mem_rts_q, mem_rts_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wben_q, mem_wben_d;

  logic        reg_free, own_rts, own_xfc, last_beat, found;
  logic [31:0] sel_data;
  logic [15:0] sel_addr;
  logic [3:0]  sel_wben;
  logic [1:0]  pick, next_ptr;
  logic [2*NUM_REQ-1:0] rts_dbl, rts_rot;

  assign reg_free  = !mem_rts_q || mem_rtr;
  assign own_xfc   = (state_q == GRANT) && own_rts && reg_free;
  assign last_beat = (burst_cnt_q + 8'd1) == 8'(MAX_BURST);
  assign next_ptr  = (owner_q == 2'(NUM_REQ-1)) ? 2'd0 : owner_q + 2'd1;

  always_comb begin
    sel_data = '0;
    sel_addr = '0;
    sel_wben = '0;
    own_rts  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 2'(i)) begin
        sel_data = req_data[32*i +: 32];
        sel_addr = req_addr[16*i +: 16];
        sel_wben = req_wben[4*i +: 4];
        own_rts  = req_rts[i];
      end
    end
  end

  // Rotating a doubled copy puts rr_ptr at bit 0, so a fixed low-first scan is fair.
  always_comb begin
    rts_dbl = {req_rts, req_rts};
    rts_rot = rts_dbl >> rr_ptr_q;
    found   = 1'b0;
    pick    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && rts_rot[k]) begin
        found = 1'b1;
        pick  = 2'((32'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = GRANT;
          owner_d     = pick;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (own_xfc) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (last_beat) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (!own_rts) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_rtr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_rtr[i] = (state_q == GRANT) && (owner_q == 2'(i)) && reg_free;
    end
    busy     = (state_q == GRANT);
    grant_id = owner_q;
    mem_rts  = mem_rts_q;
    mem_data = mem_data_q;
    mem_addr = mem_addr_q;
    mem_wben = mem_wben_q;
  end

  // The output word lives independently of the grant; only a load or a drain touches it.
  always_comb begin
    mem_rts_d  = mem_rts_q;
    mem_data_d = mem_data_q;
    mem_addr_d = mem_addr_q;
    mem_wben_d = mem_wben_q;
    if (own_xfc) begin
      mem_rts_d  = 1'b1;
      mem_data_d = sel_data;
      mem_addr_d = sel_addr;
      mem_wben_d = sel_wben;
    end else if (mem_rtr) begin
      mem_rts_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mem_rts_q  <= 1'b0;
      mem_data_q <= '0;
      mem_addr_q <= '0;
      mem_wben_q <= '0;
    end else begin
      mem_rts_q  <= mem_rts_d;
      mem_data_q <= mem_data_d;
      mem_addr_q <= mem_addr_d;
      mem_wben_q <= mem_wben_d;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter: one instance at MAX_BURST=8 carries
// data checks, a second at MAX_BURST=2 shares inputs for the rotation test.
module tb_fb_write_arbiter;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] a;
    logic [3:0]  w;
  } word_t;

  logic         clk = 1'b0;
  logic         rst_;
  logic [127:0] req_data;
  logic [63:0]  req_addr;
  logic [15:0]  req_wben;
  logic [3:0]   req_rts, req_rtr, req_rtr2;
  logic [31:0]  mem_data, mem_data2;
  logic [15:0]  mem_addr, mem_addr2;
  logic [3:0]   mem_wben, mem_wben2;
  logic         mem_rts, mem_rts2, mem_rtr;
  logic [1:0]   grant_id, grant_id2;
  logic         busy, busy2;

  word_t        srcbuf [4][32];
  logic [4:0]   hd [4];
  logic [4:0]   tl [4];
  logic [3:0]   hold;
  word_t        sb_q [$];
  logic [1:0]   rr_ids [$];
  int unsigned  xfc_cnt [4];
  int unsigned  mem_cnt;
  int           npass = 0;
  int           ntotal = 0;

  always #5 clk = ~clk;

  fb_write_arbiter #(.NUM_REQ(4), .MAX_BURST(8)) dut (
    .clk(clk), .rst_(rst_), .req_data(req_data), .req_addr(req_addr),
    .req_wben(req_wben), .req_rts(req_rts), .req_rtr(req_rtr),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_wben(mem_wben),
    .mem_rts(mem_rts), .mem_rtr(mem_rtr), .grant_id(grant_id), .busy(busy));

  fb_write_arbiter #(.NUM_REQ(4), .MAX_BURST(2)) dut2 (
    .clk(clk), .rst_(rst_), .req_data(req_data), .req_addr(req_addr),
    .req_wben(req_wben), .req_rts(req_rts), .req_rtr(req_rtr2),
    .mem_data(mem_data2), .mem_addr(mem_addr2), .mem_wben(mem_wben2),
    .mem_rts(mem_rts2), .mem_rtr(mem_rtr), .grant_id(grant_id2), .busy(busy2));

  // Each requester presents the head of its queue.
  always_comb begin
    req_rts  = '0;
    req_data = '0;
    req_addr = '0;
    req_wben = '0;
    for (int i = 0; i < 4; i++) begin
      req_rts[i]          = !hold[i] && (hd[i] != tl[i]);
      req_data[32*i +: 32] = srcbuf[i][hd[i]].d;
      req_addr[16*i +: 16] = srcbuf[i][hd[i]].a;
      req_wben[4*i +: 4]   = srcbuf[i][hd[i]].w;
    end
  end

  // One clock: observe at negedge, retire accepted words just after posedge.
  task automatic step();
    word_t      exp_w;
    logic [3:0] pend;
    pend = '0;
    @(negedge clk);
    if (rst_) begin
      if (mem_rts && mem_rtr) begin
        mem_cnt++;
        ntotal++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_word: got addr %h data %h, expected no word", mem_addr, mem_data);
        end else begin
          exp_w = sb_q.pop_front();
          if ({mem_data, mem_addr, mem_wben} !== exp_w)
            $display("FAIL sb_word: got %h/%h/%h expected %h/%h/%h",
                     mem_data, mem_addr, mem_wben, exp_w.d, exp_w.a, exp_w.w);
          else npass++;
        end
      end
      if (req_rtr != 4'b0) begin
        ntotal++;
        if ($countones(req_rtr) > 1 || (mem_rts && !mem_rtr))
          $display("FAIL rtr_legal: got req_rtr %b mem_rts %b mem_rtr %b", req_rtr, mem_rts, mem_rtr);
        else npass++;
      end
      for (int i = 0; i < 4; i++) begin
        if (req_rts[i] && req_rtr[i]) begin
          sb_q.push_back(srcbuf[i][hd[i]]);
          pend[i] = 1'b1;
          xfc_cnt[i]++;
        end
        if (req_rts[i] && req_rtr2[i]) rr_ids.push_back(grant_id2);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (pend[i]) hd[i] = hd[i] + 5'd1;
    #1;
  endtask

  task automatic clear_model();
    hold    = '0;
    mem_rtr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hd[i] = '0;
      tl[i] = '0;
      xfc_cnt[i] = 0;
    end
    sb_q.delete();
    rr_ids.delete();
    mem_cnt = 0;
  endtask

  task automatic load(input int r, input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      srcbuf[r][tl[r]].a = base + 16'(k);
      srcbuf[r][tl[r]].d = {8'hA0 | 8'(r), 8'(k), base + 16'(k)};
      srcbuf[r][tl[r]].w = 4'(k + r + 1);
      tl[r] = tl[r] + 5'd1;
    end
  endtask

  task automatic hard_reset();
    rst_ = 1'b0;
    clear_model();
    step();
    step();
    rst_ = 1'b1;
  endtask

  task automatic wait_busy(input logic lvl, input int lim, input string nm);
    int n;
    n = 0;
    while (busy !== lvl && n < lim) begin
      step();
      n++;
    end
    ntotal++;
    if (busy !== lvl) $display("FAIL %s: busy got %b expected %b within %0d cycles", nm, busy, lvl, lim);
    else npass++;
  endtask

  task automatic test_reset();
    rst_ = 1'b0;
    clear_model();
    #1;
    ntotal++;
    if (mem_rts !== 1'b0 || busy !== 1'b0) $display("FAIL reset_flags: got mem_rts %b busy %b expected 0 0", mem_rts, busy);
    else npass++;
    ntotal++;
    if ({mem_data, mem_addr, mem_wben} !== 52'h0) $display("FAIL reset_word: got %h expected 0", {mem_data, mem_addr, mem_wben});
    else npass++;
    ntotal++;
    if (grant_id !== 2'd0 || req_rtr !== 4'b0) $display("FAIL reset_grant: got id %0d rtr %b expected 0 0000", grant_id, req_rtr);
    else npass++;
    step();
    step();
    rst_ = 1'b1;
    step();
    ntotal++;
    if (busy !== 1'b0 || req_rtr !== 4'b0 || mem_rts !== 1'b0) $display("FAIL idle_no_req: got busy %b rtr %b mem_rts %b expected 0", busy, req_rtr, mem_rts);
    else npass++;
  endtask

  task automatic test_single_burst();
    logic        ev, eb;
    logic [15:0] ea;
    hard_reset();
    load(0, 10, 16'h0000);
    ntotal++;
    if (busy !== 1'b0) $display("FAIL burst_pre: busy got %b expected 0", busy);
    else npass++;
    for (int c = 1; c <= 13; c++) begin
      step();
      eb = (c <= 8) || (c >= 10 && c <= 12);
      ev = (c >= 2 && c <= 9) || c == 11 || c == 12;
      ea = (c <= 9) ? 16'(c - 2) : 16'(c - 3);
      ntotal++;
      if ({mem_rts, busy} !== {ev, eb} || (ev && mem_addr !== ea))
        $display("FAIL burst_c%0d: got rts %b busy %b addr %h expected %b %b %h", c, mem_rts, busy, mem_addr, ev, eb, ea);
      else npass++;
    end
    ntotal++;
    if (mem_cnt !== 10 || sb_q.size() != 0) $display("FAIL burst_total: got %0d words pending %0d expected 10 0", mem_cnt, sb_q.size());
    else npass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] eid;
    rst_ = 1'b0;
    clear_model();
    for (int r = 0; r < 4; r++) load(r, 12, 16'h1000 + 16'(r * 256));
    step();
    step();
    rst_ = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      ntotal++;
      if (busy2 !== ((c % 3) != 0)) $display("FAIL rr_busy_c%0d: got %b expected %b", c, busy2, (c % 3) != 0);
      else npass++;
    end
    ntotal++;
    if (rr_ids.size() < 10) $display("FAIL rr_count: got %0d transfers expected 10", rr_ids.size());
    else npass++;
    for (int k = 0; k < 10 && k < rr_ids.size(); k++) begin
      eid = 2'((k / 2) % 4);
      ntotal++;
      if (rr_ids[k] !== eid) $display("FAIL rr_id_%0d: got %0d expected %0d", k, rr_ids[k], eid);
      else npass++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    hard_reset();
    load(0, 8, 16'h2000);
    srcbuf[0][2].d = 32'hDEADBEEF;
    n = 0;
    while (!(mem_rts && mem_data == 32'hDEADBEEF) && n < 10) begin
      step();
      n++;
    end
    ntotal++;
    if (!(mem_rts && mem_data == 32'hDEADBEEF)) $display("FAIL bp_arrive: got data %h expected deadbeef", mem_data);
    else npass++;
    mem_rtr = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      ntotal++;
      if (mem_data !== 32'hDEADBEEF || mem_rts !== 1'b1 || req_rtr[0] !== 1'b0)
        $display("FAIL bp_hold_%0d: got data %h rts %b rtr0 %b expected deadbeef 1 0", k, mem_data, mem_rts, req_rtr[0]);
      else npass++;
    end
    step();
    mem_rtr = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      ntotal++;
      if (mem_rts !== 1'b1) $display("FAIL bp_resume_%0d: mem_rts got %b expected 1", k, mem_rts);
      else npass++;
    end
    for (int k = 0; k < 4; k++) step();
    ntotal++;
    if (mem_cnt !== 8 || sb_q.size() != 0) $display("FAIL bp_total: got %0d words pending %0d expected 8 0", mem_cnt, sb_q.size());
    else npass++;
  endtask

  task automatic test_early_release();
    hard_reset();
    load(1, 3, 16'h3000);
    load(2, 4, 16'h4000);
    wait_busy(1'b1, 3, "er_grant1");
    ntotal++;
    if (grant_id !== 2'd1) $display("FAIL er_owner1: got %0d expected 1", grant_id);
    else npass++;
    wait_busy(1'b0, 10, "er_release1");
    ntotal++;
    if (xfc_cnt[1] !== 3 || xfc_cnt[2] !== 0) $display("FAIL er_count: got %0d/%0d expected 3/0", xfc_cnt[1], xfc_cnt[2]);
    else npass++;
    wait_busy(1'b1, 2, "er_grant2");
    ntotal++;
    if (grant_id !== 2'd2) $display("FAIL er_owner2: got %0d expected 2", grant_id);
    else npass++;
    load(0, 2, 16'h5000);
    load(1, 2, 16'h3100);
    wait_busy(1'b0, 10, "er_release2");
    wait_busy(1'b1, 3, "er_grant0");
    ntotal++;
    if (grant_id !== 2'd0) $display("FAIL er_wrap: got %0d expected 0", grant_id);
    else npass++;
    wait_busy(1'b0, 10, "er_release0");
    wait_busy(1'b1, 3, "er_grant1b");
    ntotal++;
    if (grant_id !== 2'd1) $display("FAIL er_next: got %0d expected 1", grant_id);
    else npass++;
    for (int k = 0; k < 6; k++) step();
    ntotal++;
    if (sb_q.size() != 0 || mem_cnt !== 11) $display("FAIL er_total: got %0d words pending %0d expected 11 0", mem_cnt, sb_q.size());
    else npass++;
  endtask

  task automatic test_reset_mid();
    int n;
    hard_reset();
    load(0, 8, 16'h6000);
    n = 0;
    while (!(mem_rts && busy) && n < 10) begin
      step();
      n++;
    end
    ntotal++;
    if (!(mem_rts && busy)) $display("FAIL rm_setup: got rts %b busy %b expected 1 1", mem_rts, busy);
    else npass++;
    rst_ = 1'b0;
    #1;
    ntotal++;
    if ({mem_rts, busy, grant_id, req_rtr} !== 8'h0) $display("FAIL rm_flags: got %b expected 0", {mem_rts, busy, grant_id, req_rtr});
    else npass++;
    ntotal++;
    if ({mem_data, mem_addr, mem_wben} !== 52'h0) $display("FAIL rm_word: got %h expected 0", {mem_data, mem_addr, mem_wben});
    else npass++;
    clear_model();
    load(3, 2, 16'h7000);
    load(1, 2, 16'h7100);
    step();
    step();
    rst_ = 1'b1;
    step();
    ntotal++;
    if (busy !== 1'b1 || grant_id !== 2'd1) $display("FAIL rm_regrant: got busy %b id %0d expected 1 1", busy, grant_id);
    else npass++;
    for (int k = 0; k < 12; k++) step();
    ntotal++;
    if (mem_cnt !== 4 || sb_q.size() != 0) $display("FAIL rm_total: got %0d words pending %0d expected 4 0", mem_cnt, sb_q.size());
    else npass++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
